// File: rtl/field_mutil_sum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// field_mutil_sum: registered GF(2^4) inner product c = sum(a_i * b_i). Rev 1.0
// ---------------------------------------------------------------------------
module field_mutil_sum #(
  parameter logic [3:0] POLY = 4'b0011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] a2,
  input  logic [3:0] a3,
  input  logic [3:0] b0,
  input  logic [3:0] b1,
  input  logic [3:0] b2,
  input  logic [3:0] b3,
  output logic       out_valid,
  output logic [3:0] c
);

  // Carry-less 4x4 product, then fold bits 6..4 back in from the top down;
  // each fold clears bit k and injects POLY at position k-4.
  function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
    logic [6:0] p;
    p = 7'd0;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) p = p ^ ({3'b000, x} << i);
    end
    for (int k = 6; k >= 4; k--) begin
      if (p[k]) p = p ^ ((7'd1 << k) | ({3'b000, POLY} << (k - 4)));
    end
    return p[3:0];
  endfunction

  logic [3:0] w_sum;

  always_comb begin
    w_sum = gf_mul(a0, b0) ^ gf_mul(a1, b1) ^ gf_mul(a2, b2) ^ gf_mul(a3, b3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c         <= 4'h0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) c <= w_sum;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_field_mutil_sum.sv
`default_nettype none
// Directed and random checks of field_mutil_sum against a shift-and-add GF(16) model.
module tb_field_mutil_sum;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a0 = 4'h0, a1 = 4'h0, a2 = 4'h0, a3 = 4'h0;
  logic [3:0] b0 = 4'h0, b1 = 4'h0, b2 = 4'h0, b3 = 4'h0;
  logic       out_valid;
  logic [3:0] c;

  int errors = 0;
  int checks = 0;

  field_mutil_sum #(.POLY(4'b0011)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .out_valid(out_valid), .c(c)
  );

  always #5 clk = ~clk;

  // xtime-based multiply: independent of the DUT's reduce-after-multiply form
  function automatic logic [3:0] gf_ref(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] r;
    logic [3:0] t;
    r = 4'h0;
    t = x;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) r = r ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] xa0, xa1, xa2, xa3,
                       input logic [3:0] xb0, xb1, xb2, xb3);
    in_valid = v;
    a0 = xa0; a1 = xa1; a2 = xa2; a3 = xa3;
    b0 = xb0; b1 = xb1; b2 = xb2; b3 = xb3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ra [8];
    logic       rv;
    logic [3:0] exp_c;
    logic       exp_v;

    // reset, then release with in_valid low
    #2 rst = 1'b1;
    #1;
    chk("reset_c", c, 4'h0);
    chk("reset_valid", {3'b0, out_valid}, 4'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("idle_c", c, 4'h0);
    chk("idle_valid", {3'b0, out_valid}, 4'h0);

    // single vectors
    drive(1'b1, 4'h4, 4'h1, 4'h2, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0);
    tick();
    chk("t2_c", c, 4'h4);
    chk("t2_valid", {3'b0, out_valid}, 4'h1);

    // asynchronous reset between edges clears a live result at once
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_c", c, 4'h0);
    chk("async_rst_valid", {3'b0, out_valid}, 4'h0);
    tick();
    rst = 1'b0;
    tick();

    drive(1'b1, 4'h4, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2);
    tick();
    chk("t3_c", c, 4'hA);
    chk("t3_valid", {3'b0, out_valid}, 4'h1);

    drive(1'b1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    tick();
    chk("t4a_c", c, 4'h3);
    drive(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    tick();
    chk("t4b_c", c, 4'hA);
    drive(1'b1, 4'h9, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    tick();
    chk("t4c_c", c, 4'h1);
    // multiply by 1 is identity, in a non-zero lane
    drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'hD);
    tick();
    chk("ident_c", c, 4'hD);

    // back-to-back stream then idle
    drive(1'b1, 4'h4, 4'h1, 4'h2, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0);
    tick();
    chk("s1_c", c, 4'h4);
    chk("s1_valid", {3'b0, out_valid}, 4'h1);
    drive(1'b1, 4'h4, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2);
    tick();
    chk("s2_c", c, 4'hA);
    chk("s2_valid", {3'b0, out_valid}, 4'h1);
    drive(1'b1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    tick();
    chk("s3_c", c, 4'h3);
    chk("s3_valid", {3'b0, out_valid}, 4'h1);
    // inputs wiggle while in_valid is low: c must hold
    drive(1'b0, 4'hF, 4'hE, 4'hD, 4'hC, 4'h7, 4'h6, 4'h5, 4'h4);
    tick();
    chk("hold_c", c, 4'h3);
    chk("hold_valid", {3'b0, out_valid}, 4'h0);
    drive(1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h9, 4'h9, 4'h9, 4'h9);
    tick();
    chk("hold2_c", c, 4'h3);

    // random run with a mid-run reset pulse
    exp_c = 4'h3;
    exp_v = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (n == 500) begin
        drive(1'b1, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_c", c, 4'h0);
        chk("mid_rst_valid", {3'b0, out_valid}, 4'h0);
        tick();
        chk("mid_rst_edge_valid", {3'b0, out_valid}, 4'h0);
        rst = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick();
        chk("post_rst_c", c, 4'h0);
        chk("post_rst_valid", {3'b0, out_valid}, 4'h0);
        exp_c = 4'h0;
      end
      for (int j = 0; j < 8; j++) ra[j] = 4'($urandom_range(0, 15));
      rv = ($urandom_range(0, 3) != 0);
      drive(rv, ra[0], ra[1], ra[2], ra[3], ra[4], ra[5], ra[6], ra[7]);
      if (rv) exp_c = gf_ref(ra[0], ra[4]) ^ gf_ref(ra[1], ra[5]) ^
                      gf_ref(ra[2], ra[6]) ^ gf_ref(ra[3], ra[7]);
      exp_v = rv;
      tick();
      chk("rand_c", c, exp_c);
      chk("rand_valid", {3'b0, out_valid}, {3'b0, exp_v});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
